// File: rtl/jpeg_bytestuffer_fifo_pkg.sv
// Shared definitions for the JPEG byte stuffer and the marker inserter.
package jpeg_bytestuffer_fifo_pkg;

  // Output FSM states of the stuffing FIFO
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    ZERO  = 2'd3
  } bs_state_t;

  // A data byte equal to the trigger is followed by the stuff byte
  localparam logic [7:0] JPEG_STUFF_TRIGGER = 8'hff;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;

  // Width of one stored entry: {raw, data}
  localparam int JPEG_ENTRY_WIDTH = 9;

endpackage

// File: rtl/jpeg_bytestuffer_fifo_ebr.sv
// Simple dual-port block RAM with a common clock and a registered read port
// (iCE40 EBR style). The read data holds its value while rd_en is low.
module jpeg_bytestuffer_fifo_ebr #(
  parameter int addr_width = 9,
  parameter int data_width = 9
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [0:(1<<addr_width)-1];

  // Synchronous write and registered read; no reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jpeg_bytestuffer_fifo.sv
// JPEG byte stuffer with a block-RAM FIFO. Bytes flagged raw (markers) pass
// verbatim; every other byte equal to STUFF_TRIGGER is followed by STUFF_BYTE.
//
// Handshakes: on both sides a byte moves on a rising clock edge where valid
// and ready are both high. A producer never withdraws or changes a valid byte
// before it is taken: out_valid/out_data stay stable while out_ready is low.
// in_ready depends only on registered state (not full).
//
// Read pipeline: out_data holds the byte being offered; at most one more byte
// is in flight beyond it, either as RAM read data arriving this cycle
// (rd_pending) or parked in the one-entry skid register.
module jpeg_bytestuffer_fifo
  import jpeg_bytestuffer_fifo_pkg::*;
#(
  parameter int         ADDR_WIDTH         = 9,
  parameter logic [7:0] STUFF_TRIGGER      = JPEG_STUFF_TRIGGER,
  parameter logic [7:0] STUFF_BYTE         = JPEG_STUFF_BYTE,
  parameter int         ALMOST_FULL_MARGIN = 16
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_raw,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [ADDR_WIDTH:0] level,
  output logic                almost_full,
  output logic                overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_V  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] MARGIN_V = (ADDR_WIDTH+1)'(ALMOST_FULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]           wr_ptr;
  logic [ADDR_WIDTH:0]           rd_ptr;
  logic                          full;
  logic                          empty;
  logic                          wr_en;
  logic [ADDR_WIDTH:0]           free_cnt;
  logic [JPEG_ENTRY_WIDTH-1:0]   rd_word;
  logic [JPEG_ENTRY_WIDTH-1:0]   skid_data;
  logic [JPEG_ENTRY_WIDTH-1:0]   next_word;
  logic                          skid_valid;
  logic                          rd_pending;
  logic                          out_raw;
  bs_state_t                     state;

  logic hs;
  logic ahead;
  logic stuff_now;
  logic advance;
  logic consume;
  logic rd_issue;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign in_ready = !full;
  assign wr_en    = in_valid && !full;

  assign level       = wr_ptr - rd_ptr;
  assign free_cnt    = DEPTH_V - level;
  assign almost_full = (free_cnt <= MARGIN_V);

  // The byte that follows out_data: the skid entry has priority because it
  // was read earlier than anything currently arriving from the RAM.
  assign next_word = skid_valid ? skid_data : rd_word;

  jpeg_bytestuffer_fifo_ebr #(
    .addr_width (ADDR_WIDTH),
    .data_width (JPEG_ENTRY_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data ({in_raw, in_data}),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_word)
  );

  // Decide this cycle's output move and whether a RAM read can be issued
  always_comb begin
    hs        = out_valid && out_ready;
    ahead     = skid_valid || rd_pending;
    stuff_now = (state == EMIT) && hs && (out_data == STUFF_TRIGGER) && !out_raw;
    advance   = hs && (((state == EMIT) && !stuff_now) || (state == ZERO));
    consume   = ahead && ((state == FETCH) || advance);
    // Keep at most one byte in flight beyond out_data
    rd_issue  = !empty && (!ahead || consume);
  end

  // Write and read pointers; wrap is natural modulo 2**(ADDR_WIDTH+1)
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky overflow: a byte was offered while the buffer was full
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      overflow <= 1'b0;
    end else if (in_valid && full) begin
      overflow <= 1'b1;
    end
  end

  // Track RAM read data in flight and park it in the skid when not consumed
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rd_pending <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      rd_pending <= rd_issue;
      if (consume && skid_valid) begin
        skid_valid <= 1'b0;
      end else if (rd_pending && !consume) begin
        skid_valid <= 1'b1;
        skid_data  <= rd_word;
      end
    end
  end

  // Output FSM with registered out_valid/out_data
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_raw   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (rd_issue) state <= FETCH;
        end
        FETCH: begin
          out_data  <= rd_word[7:0];
          out_raw   <= rd_word[8];
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT, ZERO: begin
          if (stuff_now) begin
            out_data <= STUFF_BYTE;
            state    <= ZERO;
          end else if (advance) begin
            if (ahead) begin
              out_data  <= next_word[7:0];
              out_raw   <= next_word[8];
              out_valid <= 1'b1;
              state     <= EMIT;
            end else if (rd_issue) begin
              // A read went out this cycle; pick it up without passing IDLE
              out_valid <= 1'b0;
              state     <= FETCH;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_bytestuffer_fifo.sv
// Directed bench for the JPEG byte stuffing FIFO (16-entry instance).
module tb_jpeg_bytestuffer_fifo;

  localparam int AW = 4;

  logic          clock;
  logic          nreset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_raw;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [AW:0]   level;
  logic          almost_full;
  logic          overflow;

  int n_vec  = 0;
  int n_miss = 0;
  int out_idx = 0;
  logic [7:0] exp_q[$];

  jpeg_bytestuffer_fifo #(
    .ADDR_WIDTH         (AW),
    .ALMOST_FULL_MARGIN (4)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_raw      (in_raw),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare and count
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted output byte must be the next expected one
  always @(negedge clock) begin
    if (nreset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_out: got %02h with nothing expected", out_data);
      end else begin
        check($sformatf("out_byte[%0d]", out_idx), {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
      out_idx++;
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic r, output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    in_raw   = r;
    @(negedge clock);
    acc = in_ready;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clock);
      t++;
    end
    #1;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Vector table: bytes are stored most significant first
  typedef struct {
    logic [63:0] din;
    logic [7:0]  raw;
    int          n_in;
    logic [95:0] dout;
    int          n_out;
    logic        ready_push;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input int v);
    logic acc;
    out_ready = vecs[v].ready_push;
    for (int i = 0; i < vecs[v].n_out; i++)
      exp_q.push_back(vecs[v].dout[95-8*i -: 8]);
    for (int i = 0; i < vecs[v].n_in; i++) begin
      push_byte(vecs[v].din[63-8*i -: 8], vecs[v].raw[7-i], acc);
      check($sformatf("vec%0d_accept[%0d]", v, i), acc, 1);
    end
    out_ready = 1'b1;
    wait_drain($sformatf("vec%0d_drain", v));
    idle(4);
    check($sformatf("vec%0d_level", v), level, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic acc;
    vecs[0] = '{64'h12FF34FFFF000000, 8'b0000_0000, 5, 96'h12FF0034_FF00FF00_00000000, 8, 1'b0};
    vecs[1] = '{64'hFFD9FF0000000000, 8'b1100_0000, 3, 96'hFFD9FF00_00000000_00000000, 4, 1'b0};
    vecs[2] = '{64'hA0FFFFB1C2FF0000, 8'b0000_0000, 6, 96'hA0FF00FF_00B1C2FF_00000000, 9, 1'b1};
    vecs[3] = '{64'hFFFF000000000000, 8'b1000_0000, 3, 96'hFFFF0000_00000000_00000000, 4, 1'b1};

    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_raw    = 1'b0;
    out_ready = 1'b0;
    idle(3);
    nreset = 1'b1;
    idle(1);

    // Reset state
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow", overflow, 0);
    idle(1);

    // Passthrough with first-byte latency
    out_ready = 1'b1;
    exp_q.push_back(8'h01);
    push_byte(8'h01, 1'b0, acc);
    check("pt_accept", acc, 1);
    @(negedge clock);
    check("pt_lat_n1", out_valid, 0);
    @(negedge clock);
    check("pt_lat_n2", out_valid, 0);
    @(negedge clock);
    check("pt_lat_n3_valid", out_valid, 1);
    check("pt_lat_n3_data", out_data, 8'h01);
    @(posedge clock);
    #1;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    push_byte(8'h02, 1'b0, acc);
    push_byte(8'h03, 1'b0, acc);
    wait_drain("pt_drain");
    idle(3);
    check("pt_level", level, 0);
    out_ready = 1'b0;

    // Table-driven stuffing / raw marker vectors
    for (int v = 0; v < 4; v++) run_vec(v);

    // Backpressure: FF held for 10 cycles, then FF 00 exactly once
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    push_byte(8'hFF, 1'b0, acc);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("bp_valid[%0d]", i), out_valid, 1);
      check($sformatf("bp_data[%0d]", i), out_data, 8'hFF);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");
    idle(4);
    out_ready = 1'b0;

    // Fill to full: two bytes sit outside the RAM (out_data and skid)
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      push_byte(8'h20 + 8'(i), 1'b0, acc);
    end
    idle(3);
    @(negedge clock);
    check("fill_level11", level, 11);
    check("fill_af_off", almost_full, 0);
    @(posedge clock);
    #1;
    exp_q.push_back(8'h2D);
    push_byte(8'h2D, 1'b0, acc);
    @(negedge clock);
    check("fill_level12", level, 12);
    check("fill_af_on", almost_full, 1);
    @(posedge clock);
    #1;
    for (int i = 14; i < 18; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      push_byte(8'h20 + 8'(i), 1'b0, acc);
      check($sformatf("fill_accept[%0d]", i), acc, 1);
    end
    @(negedge clock);
    check("full_level", level, 16);
    check("full_in_ready", in_ready, 0);
    check("full_overflow_pre", overflow, 0);
    @(posedge clock);
    #1;
    push_byte(8'h99, 1'b0, acc);
    check("ovf_dropped", acc, 0);
    @(negedge clock);
    check("ovf_sticky", overflow, 1);
    check("ovf_level", level, 16);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    idle(3);
    check("ovf_drained_level", level, 0);
    check("ovf_still_set", overflow, 1);
    out_ready = 1'b0;

    // Three more refills across the pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 18; i++) begin
        exp_q.push_back(8'h60 + 8'(r * 32) + 8'(i));
        push_byte(8'h60 + 8'(r * 32) + 8'(i), 1'b0, acc);
      end
      idle(2);
      @(negedge clock);
      check($sformatf("refill%0d_level", r), level, 16);
      check($sformatf("refill%0d_full", r), in_ready, 0);
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      wait_drain($sformatf("refill%0d_drain", r));
      idle(3);
      out_ready = 1'b0;
    end

    // Reset between FF and its stuff byte
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    push_byte(8'hFF, 1'b0, acc);
    idle(3);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check("rst_mid_zero_valid", out_valid, 1);
    check("rst_mid_zero_data", out_data, 8'h00);
    nreset = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_level", level, 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    nreset = 1'b1;
    check("rst_mid_overflow", overflow, 0);
    out_ready = 1'b1;
    exp_q.push_back(8'h55);
    push_byte(8'h55, 1'b0, acc);
    wait_drain("rst_mid_drain");
    idle(6);
    check("rst_mid_final_level", level, 0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
